// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: owns the PC and fetches one word at a time from imem.
// It holds the fetched instruction until retire, and handles flush, stale responses and misaligned targets.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0040_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] program_counter_new,
  input  logic        retire,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] program_counter,
  output logic [31:0] program_counter_plus_4,
  output logic        misaligned_fault
);
  typedef enum logic [2:0] {S_REQ, S_WAIT, S_HOLD, S_FAULT, S_DRAIN} state_t;
  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt, r_instr, w_instr_nxt;
  logic        r_valid, w_valid_nxt, r_fault, w_fault_nxt;
  logic        w_flush_bad, w_tgt_bad, w_outstanding;
  assign w_flush_bad = flush_pc[1:0] != 2'b00;
  assign w_tgt_bad   = program_counter_new[1:0] != 2'b00;
  // A flush leaves a request in flight if one is accepted now or is still awaiting its response
  assign w_outstanding = (r_state == S_REQ && imem_req_ready) ||
                         ((r_state == S_WAIT || r_state == S_DRAIN) && !imem_rsp_valid);
  assign imem_req_valid         = rst_n && r_state == S_REQ;
  assign imem_req_addr          = r_pc;
  assign instr_valid            = r_valid;
  assign instr                  = r_instr;
  assign program_counter        = r_pc;
  assign program_counter_plus_4 = r_pc + 32'd4;
  assign misaligned_fault       = r_fault;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_REQ;
      r_pc    <= RESET_PC;
      r_instr <= NOP_INSTR;
      r_valid <= 1'b0;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_instr <= w_instr_nxt;
      r_valid <= w_valid_nxt;
      r_fault <= w_fault_nxt;
    end
  end
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_instr_nxt = r_instr;
    w_valid_nxt = r_valid;
    w_fault_nxt = r_fault;
    if (flush) begin
      w_pc_nxt    = flush_pc;
      w_instr_nxt = NOP_INSTR;
      w_valid_nxt = 1'b0;
      w_fault_nxt = r_fault | w_flush_bad;
      w_state_nxt = w_outstanding ? S_DRAIN : (w_flush_bad ? S_FAULT : S_REQ);
    end else begin
      case (r_state)
        S_REQ:  if (imem_req_ready) w_state_nxt = S_WAIT;
        S_WAIT: if (imem_rsp_valid) begin
          w_instr_nxt = imem_rsp_data;
          w_valid_nxt = 1'b1;
          w_state_nxt = S_HOLD;
        end
        S_HOLD: if (retire) begin
          w_valid_nxt = 1'b0;
          w_instr_nxt = NOP_INSTR;
          w_fault_nxt = r_fault | w_tgt_bad;
          w_pc_nxt    = w_tgt_bad ? r_pc : program_counter_new;
          w_state_nxt = w_tgt_bad ? S_FAULT : S_REQ;
        end
        // r_pc already holds the flush target, so its alignment picks where the drain ends
        S_DRAIN: if (imem_rsp_valid) w_state_nxt = (r_pc[1:0] != 2'b00) ? S_FAULT : S_REQ;
        default: ;
      endcase
    end
  end
endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Sequential fetch stage that consumes the next-PC value computed in the fe stage and owns the architectural program counter register. It issues word fetches to instruction memory over a valid/ready request plus response-valid interface. It holds the fetched instruction stable for the core until the core retires it, then loads the next PC. It supports an external flush/redirect, drops stale responses after a flush, and flags misaligned targets.

Parameters:
RESET_PC, 32'h0040_0000, PC value loaded on reset.
NOP_INSTR, 32'h0000_0013, value driven on instr when no valid instruction is held (addi x0,x0,0).

Ports:
clk  input  1  core clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
program_counter_new  input  32  next PC from the fe next-PC selection logic
retire  input  1  core has completed the held instruction this cycle
flush  input  1  external redirect request
flush_pc  input  32  redirect target, sampled when flush=1
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request
imem_req_addr  output  32  word address (always equal to program_counter)
imem_rsp_valid  input  1  read data valid; exactly one response per accepted request, at least 1 cycle after acceptance
imem_rsp_data  input  32  read data
instr_valid  output  1  instr holds a fetched instruction for program_counter
instr  output  32  held instruction
program_counter  output  32  current PC
program_counter_plus_4  output  32  program_counter + 4, mod 2^32, combinational
misaligned_fault  output  1  sticky, target PC had bits[1:0] != 0

Behaviour:
- Reset (asynchronous, rst_n=0):
  - program_counter=RESET_PC, instr=NOP_INSTR, instr_valid=0, misaligned_fault=0, state=S_REQ.
  - imem_req_valid is forced 0 while rst_n=0.
  - The first request is issued in the first cycle after release.
- S_REQ:
  - imem_req_valid=1, imem_req_addr=program_counter.
  - imem_req_valid stays asserted until imem_req_ready. Address is held stable.
  - On handshake -> S_WAIT.
- S_WAIT:
  - imem_req_valid=0.
  - On imem_rsp_valid: instr<=imem_rsp_data, instr_valid<=1, -> S_HOLD. Fetch latency = 1 request cycle + memory latency.
- S_HOLD:
  - instr_valid=1. instr and program_counter are held.
  - On retire: if program_counter_new[1:0]==0, program_counter<=program_counter_new, instr_valid<=0, instr<=NOP_INSTR, -> S_REQ.
  - On retire with a misaligned target: misaligned_fault<=1, instr_valid<=0, -> S_FAULT. The PC is not updated.
- S_FAULT:
  - No requests, instr_valid=0.
  - Left only via reset or flush.
- S_DRAIN:
  - Waits for the orphaned response and discards it (instr is not written, instr_valid stays 0).
  - On imem_rsp_valid -> S_REQ.
- flush (any state, priority over retire):
  - program_counter<=flush_pc, instr_valid<=0, instr<=NOP_INSTR.
  - Next state is S_DRAIN if in S_WAIT and imem_rsp_valid=0 that cycle, or if in S_DRAIN and imem_rsp_valid=0 that cycle.
  - Next state is S_DRAIN if in S_REQ with imem_req_ready=1 that cycle (that request was accepted).
  - Otherwise the next state is S_REQ.
  - A response arriving in the same cycle as the flush is discarded.
  - A misaligned flush_pc sets misaligned_fault and the next state is S_FAULT. If a request is outstanding (the S_DRAIN cases above), the block passes through S_DRAIN first, then goes to S_FAULT instead of S_REQ.
  - misaligned_fault clears only on reset.
- retire outside S_HOLD is ignored.
- imem_rsp_valid outside S_WAIT/S_DRAIN is ignored.
- PC arithmetic is unsigned 32-bit wrap: 32'hFFFF_FFFC + 4 = 0.

Test Plan:
- Reset release, memory ready=1, 2-cycle latency, rsp 32'h00500093 → req_addr=0x00400000 in cycle 1, instr_valid=1 with instr=0x00500093 two cycles after acceptance.
- Sequential stream: retire with program_counter_new=program_counter_plus_4 three times → request addresses 0x00400004, 0x00400008, 0x0040000C in order.
- Backpressure: imem_req_ready=0 for 4 cycles → req_valid held 1 and req_addr stable for 4 cycles, single acceptance, single response captured.
- Flush while in S_WAIT, flush_pc=0x00400100 → old response discarded, next req_addr=0x00400100, fetched instr from 0x00400100 presented.
- Retire with program_counter_new=0x00400102 → misaligned_fault=1, instr_valid=0, no further requests; later flush to 0x00400000 resumes fetching with fault still 1.
- Reset asserted mid-S_WAIT → outputs immediately return to reset values (instr=0x00000013, instr_valid=0), PC=0x00400000.
